reloj_hms: RTL and testbench
============================

# reloj_hms

Time-of-day counter that sits directly downstream of the 1-second square-wave generator. It consumes that generator's `SEGUNDO` output, detects one rising edge per second in the `mclk` domain, and keeps hours, minutes and seconds in packed BCD for the 7-segment display driver. A three-state mode FSM lets the user set hours and minutes with two button inputs.

## Interface
- `HH_MAX`, default 8'h23, last valid hour in BCD (24-hour format).
- `MS_MAX`, default 8'h59, last valid minute/second in BCD.
- `mclk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low
- `seg_in`  in  1  1 s square wave from the second generator, synchronous to `mclk`
- `btn_mode`  in  1  debounced mode button, level; rising edge acts
- `btn_inc`  in  1  debounced increment button, level; rising edge acts
- `hh_bcd`  out  8  hours, BCD {tens,units}
- `mm_bcd`  out  8  minutes, BCD
- `ss_bcd`  out  8  seconds, BCD
- `mode`  out  2  current FSM state (RUN=0, SET_HH=1, SET_MM=2)
- `tick`  out  1  one-cycle pulse per detected second
- `al_hh`, `al_mm`  in  8 each  alarm time, BCD (only with `RELOJ_ALARM_EN`)
- `alarm`  out  1  alarm active (only with `RELOJ_ALARM_EN`)

Clocking: `reset` is asynchronous and active-low. The clock is `mclk`.

## Operation
- Edge detect:
  - `tick = seg_in & ~seg_q`, where `seg_q` is registered `seg_in`.
  - Same scheme for `btn_mode` and `btn_inc`.
  - All `*_q` registers reset to 1, so a line that is high at reset release does not fire.
- FSM states:
  - RUN: on `tick`, `ss` increments. At `MS_MAX`, `ss` wraps to 00 and carries to `mm`. At `MS_MAX`, `mm` wraps and carries to `hh`. At `HH_MAX`, `hh` wraps to 00. So 23:59:59 → 00:00:00.
  - SET_HH: ticks are ignored. A `btn_inc` edge does `hh+1` mod 24, with no carry.
  - SET_MM: ticks are ignored. A `btn_inc` edge does `mm+1` mod 60, with no carry.
- Transitions on a `btn_mode` edge:
  - RUN → SET_HH
  - SET_HH → SET_MM
  - SET_MM → RUN, and `ss` is cleared to 00 on that transition.
- Same-cycle events:
  - `btn_mode` edge with `btn_inc` edge: the mode change wins and the increment is dropped.
  - `btn_mode` edge with `tick` in RUN: the tick is applied, then the state becomes SET_HH.
  - `btn_inc` in RUN has no effect on time (used only for alarm clear).
- BCD arithmetic:
  - Units digit 9 → 0 with carry into tens.
  - The wrap comparison is against the full 8-bit max value, never binary.
  - Digits never leave the 0–9 range.
- Reset (asynchronous, any time):
  - 00:00:00, `mode` = RUN, `tick` = 0, `alarm` = 0.
  - Any operation in progress is abandoned.

## Timing
- `tick` is high during the `mclk` cycle in which `seg_in` = 1 and `seg_q` = 0.
- Counters update on that same rising edge, so outputs change 1 `mclk` after `seg_in` is sampled high.
- Button actions take effect on the `mclk` edge where the edge is detected, i.e. 1-cycle latency.
- All outputs are registered except `tick` (combinational from a registered and a registered-input term).
- Minimum `seg_in` high and low time is 1 `mclk`; shorter pulses are not guaranteed to be seen.

## Configuration
- `RELOJ_ALARM_EN` defined:
  - Adds the `al_hh`, `al_mm` and `alarm` ports.
  - `alarm` sets on the RUN tick that produces `al_hh:al_mm:00`.
  - It clears on a `btn_inc` edge in RUN, on the next `mm` change, or on reset.
  - Entering SET_HH also clears it.
- `RELOJ_ALARM_EN` undefined:
  - The ports and the comparator are absent.
  - Behaviour is otherwise identical.

## Structure
- Shared package / include `reloj_defs`:
  - Mode encodings RUN/SET_HH/SET_MM.
  - BCD limits 8'h59 and 8'h23.
  - BCD digit width.
- Sub-module `bcd_mod_counter`:
  - 8-bit BCD counter with `inc`, `clr` and a max-value parameter.
  - Outputs `carry` (inc at max).
  - Instantiated three times: ss, mm, hh.

## Test plan
- Reset, hold `seg_in` = 1, release reset → no tick. The first 0→1 of `seg_in` produces `tick` and `ss_bcd` = 8'h01 one cycle later.
- Preload via set mode to 23:59, return to RUN (ss = 00), apply 59 ticks, then one more → `hh_bcd`/`mm_bcd`/`ss_bcd` = 00/00/00.
- SET_HH: press `btn_inc` 25 times from 00 → `hh_bcd` = 8'h01. Ticks during set leave `ss_bcd` unchanged.
- Same-cycle `btn_mode` and `btn_inc` edge in SET_MM → `mode` = RUN, `mm_bcd` unchanged, `ss_bcd` = 00.
- Assert `reset` mid-run at 12:34:56 → outputs 00:00:00 and `mode` = 0 immediately, without waiting for an `mclk` edge.
- With `RELOJ_ALARM_EN`, `al_hh`/`al_mm` = 8'h00/8'h01, run 60 ticks from 00:00:00 → `alarm` = 1 at 00:01:00. A `btn_inc` edge → `alarm` = 0 next cycle.

Source files
------------

// File: rtl/reloj_defs.sv
// Shared definitions for the BCD time-of-day clock: mode encodings,
// BCD limits and the one-step BCD increment helper.
package reloj_defs;

  localparam int unsigned BCD_W = 4;
  localparam logic [7:0]  MS_LIM = 8'h59;
  localparam logic [7:0]  HH_LIM = 8'h23;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2
  } mode_t;

  // Units 9 rolls to 0 and bumps tens; the caller handles the max wrap.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
    tens  = v[7:4];
    units = v[3:0];
    if (units == 4'd9) begin
      units = 4'd0;
      tens  = tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter that wraps to 00 after MAX; carry flags
// an increment taken while sitting at MAX.
module bcd_mod_counter
  import reloj_defs::*;
#(
  parameter logic [7:0] MAX = MS_LIM
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] q,
  output logic       carry
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    carry = inc && (cnt_q == MAX);
    if (clr) begin
      cnt_d = 8'h00;
    end else if (inc) begin
      cnt_d = (cnt_q == MAX) ? 8'h00 : bcd_inc(cnt_q);
    end
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) cnt_q <= 8'h00;
    else        cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/reloj_hms.sv
// HH:MM:SS BCD clock driven by the 1 s square wave, with a RUN/SET_HH/SET_MM
// mode FSM. Define RELOJ_ALARM_EN to add the alarm comparator and ports.
module reloj_hms
  import reloj_defs::*;
#(
  parameter logic [7:0] HH_MAX = HH_LIM,
  parameter logic [7:0] MS_MAX = MS_LIM
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       seg_in,
  input  logic       btn_mode,
  input  logic       btn_inc,
`ifdef RELOJ_ALARM_EN
  input  logic [7:0] al_hh,
  input  logic [7:0] al_mm,
  output logic       alarm,
`endif
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic [1:0] mode,
  output logic       tick
);

  // Edge-detect history resets high so a line already high at release is quiet.
  logic  seg_q, seg_d, bm_q, bm_d, bi_q, bi_d;
  mode_t state_q, state_d;
  logic  mode_e, inc_e;
  logic  ss_inc, mm_inc, hh_inc, ss_clr;
  logic  ss_carry, mm_carry, unused_hh_carry;

  always_comb begin
    seg_d   = seg_in;
    bm_d    = btn_mode;
    bi_d    = btn_inc;
    tick    = seg_in & ~seg_q;
    mode_e  = btn_mode & ~bm_q;
    inc_e   = btn_inc & ~bi_q;
    state_d = state_q;
    ss_inc  = 1'b0;
    mm_inc  = 1'b0;
    hh_inc  = 1'b0;
    ss_clr  = 1'b0;
    case (state_q)
      RUN: begin
        ss_inc = tick;
        mm_inc = ss_carry;
        hh_inc = mm_carry;
        if (mode_e) state_d = SET_HH;
      end
      SET_HH: begin
        if (mode_e) state_d = SET_MM;
        else        hh_inc  = inc_e;
      end
      SET_MM: begin
        if (mode_e) begin
          state_d = RUN;
          ss_clr  = 1'b1;
        end else begin
          mm_inc = inc_e;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      seg_q   <= 1'b1;
      bm_q    <= 1'b1;
      bi_q    <= 1'b1;
      state_q <= RUN;
    end else begin
      seg_q   <= seg_d;
      bm_q    <= bm_d;
      bi_q    <= bi_d;
      state_q <= state_d;
    end
  end

  bcd_mod_counter #(.MAX(MS_MAX)) u_ss (
    .mclk(mclk), .reset(reset), .inc(ss_inc), .clr(ss_clr),
    .q(ss_bcd), .carry(ss_carry)
  );

  bcd_mod_counter #(.MAX(MS_MAX)) u_mm (
    .mclk(mclk), .reset(reset), .inc(mm_inc), .clr(1'b0),
    .q(mm_bcd), .carry(mm_carry)
  );

  bcd_mod_counter #(.MAX(HH_MAX)) u_hh (
    .mclk(mclk), .reset(reset), .inc(hh_inc), .clr(1'b0),
    .q(hh_bcd), .carry(unused_hh_carry)
  );

  assign mode = state_q;

`ifdef RELOJ_ALARM_EN
  logic       alarm_q, alarm_d, hit;
  logic [7:0] mm_nx, hh_nx;

  // Hit on the RUN tick that rolls seconds to 00 and lands on al_hh:al_mm.
  always_comb begin
    mm_nx   = mm_carry ? 8'h00 : bcd_inc(mm_bcd);
    hh_nx   = mm_carry ? ((hh_bcd == HH_MAX) ? 8'h00 : bcd_inc(hh_bcd)) : hh_bcd;
    hit     = (state_q == RUN) && ss_carry && (mm_nx == al_mm) && (hh_nx == al_hh);
    alarm_d = alarm_q;
    if (mm_inc) alarm_d = 1'b0;
    if (hit)    alarm_d = 1'b1;
    if ((state_q == RUN) && (inc_e || mode_e)) alarm_d = 1'b0;
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) alarm_q <= 1'b0;
    else        alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_reloj_hms.sv
// Directed bench for reloj_hms: reset behaviour, wraps, set modes,
// same-cycle button/tick interactions and async reset.
module tb_reloj_hms;

  logic       mclk = 1'b0;
  logic       reset = 1'b0;
  logic       seg_in = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [7:0] hh_bcd, mm_bcd, ss_bcd;
  logic [1:0] mode;
  logic       tick;
`ifdef RELOJ_ALARM_EN
  logic [7:0] al_hh = 8'h00;
  logic [7:0] al_mm = 8'h01;
  logic       alarm;
`endif

  int passed = 0;
  int total  = 0;

  reloj_hms dut (
    .mclk(mclk), .reset(reset), .seg_in(seg_in),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
`ifdef RELOJ_ALARM_EN
    .al_hh(al_hh), .al_mm(al_mm), .alarm(alarm),
`endif
    .hh_bcd(hh_bcd), .mm_bcd(mm_bcd), .ss_bcd(ss_bcd),
    .mode(mode), .tick(tick)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic sec();
    seg_in = 1'b0;
    cyc(1);
    seg_in = 1'b1;
    cyc(1);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    cyc(1);
    btn_mode = 1'b0;
    cyc(1);
  endtask

  task automatic press_inc(input int n);
    repeat (n) begin
      btn_inc = 1'b1;
      cyc(1);
      btn_inc = 1'b0;
      cyc(1);
    end
  endtask

  task automatic chk_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s);
    chk({tag, "_hh"}, hh_bcd, h);
    chk({tag, "_mm"}, mm_bcd, m);
    chk({tag, "_ss"}, ss_bcd, s);
  endtask

  initial begin
    // Reset with seg_in held high; release must not produce a tick.
    #23;
    chk_time("rst", 8'h00, 8'h00, 8'h00);
    chk("rst_mode", {6'd0, mode}, 8'h00);
    chk("rst_tick", {7'd0, tick}, 8'h00);
    @(negedge mclk);
    reset = 1'b1;
    cyc(3);
    chk("rel_tick", {7'd0, tick}, 8'h00);
    chk("rel_ss", ss_bcd, 8'h00);

    // First rising edge of seg_in: tick now, ss one cycle later.
    seg_in = 1'b0;
    cyc(1);
    seg_in = 1'b1;
    #1;
    chk("t1_tick", {7'd0, tick}, 8'h01);
    chk("t1_ss_pre", ss_bcd, 8'h00);
    cyc(1);
    chk("t1_ss", ss_bcd, 8'h01);
    chk("t1_tick_lo", {7'd0, tick}, 8'h00);

    // Preload 23:59 through the set modes; ticks ignored while setting.
    press_mode();
    chk("m_sethh", {6'd0, mode}, 8'h01);
    press_inc(23);
    sec();
    chk("sethh_23", hh_bcd, 8'h23);
    chk("sethh_ss_hold", ss_bcd, 8'h01);
    press_mode();
    chk("m_setmm", {6'd0, mode}, 8'h02);
    press_inc(59);
    chk("setmm_59", mm_bcd, 8'h59);
    press_mode();
    chk("m_run", {6'd0, mode}, 8'h00);
    chk_time("pre", 8'h23, 8'h59, 8'h00);

    // 59 seconds, then the midnight rollover.
    repeat (59) sec();
    chk_time("t59", 8'h23, 8'h59, 8'h59);
    sec();
    chk_time("wrap", 8'h00, 8'h00, 8'h00);

    // btn_inc in RUN leaves time alone.
    repeat (3) sec();
    press_inc(1);
    chk_time("run_inc", 8'h00, 8'h00, 8'h03);

    // SET_HH: 25 increments from 00 wraps through 23 to 01.
    press_mode();
    press_inc(25);
    sec();
    chk("hh25", hh_bcd, 8'h01);
    chk("hh25_ss_hold", ss_bcd, 8'h03);
    chk("hh25_mm", mm_bcd, 8'h00);

    // SET_MM: 5 increments, then mode+inc in the same cycle.
    press_mode();
    press_inc(5);
    chk("mm5", mm_bcd, 8'h05);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    cyc(1);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    chk("both_mode", {6'd0, mode}, 8'h00);
    chk_time("both", 8'h01, 8'h05, 8'h00);
    cyc(1);

    // Mode edge with tick in RUN: tick applied, then SET_HH.
    seg_in = 1'b0;
    cyc(1);
    seg_in   = 1'b1;
    btn_mode = 1'b1;
    cyc(1);
    btn_mode = 1'b0;
    chk("mt_ss", ss_bcd, 8'h01);
    chk("mt_mode", {6'd0, mode}, 8'h01);

    // Move to 12:34:56 then assert reset between edges.
    press_inc(11);
    press_mode();
    press_inc(29);
    press_mode();
    repeat (56) sec();
    chk_time("pre_rst", 8'h12, 8'h34, 8'h56);
    #3;
    reset = 1'b0;
    #1;
    chk_time("async_rst", 8'h00, 8'h00, 8'h00);
    chk("async_mode", {6'd0, mode}, 8'h00);
    @(negedge mclk);
    reset = 1'b1;
    cyc(1);

`ifdef RELOJ_ALARM_EN
    chk("al_rst", {7'd0, alarm}, 8'h00);
    repeat (59) sec();
    chk("al_59", {7'd0, alarm}, 8'h00);
    sec();
    chk_time("al_time", 8'h00, 8'h01, 8'h00);
    chk("al_set", {7'd0, alarm}, 8'h01);
    btn_inc = 1'b1;
    #1;
    chk("al_hold", {7'd0, alarm}, 8'h01);
    cyc(1);
    btn_inc = 1'b0;
    chk("al_clr", {7'd0, alarm}, 8'h00);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
